soc_system_estop_supervisor: RTL and testbench
==============================================

// Module: soc_system_estop_supervisor
// PURPOSE
//  Supervises the emergency-stop input for the motor-control fabric. It filters
//  the raw e-stop pin and latches a trip on assertion. It sequences the drive
//  enables and brake through IDLE/RUN/TRIPPED/HOLDOFF states.
//  Exposes status/control to the HPS over a 4-word Avalon-MM slave with an IRQ.
// PARAMETERS
//  NUM_AXES          4      number of drive_enable bits / axis mask width
//  DEBOUNCE_CYCLES   50000  consecutive inactive samples needed to declare release (1 ms @ 50 MHz)
//  HOLDOFF_CYCLES    5000   wait after CLEAR before returning to IDLE
//  ESTOP_ACTIVE_LOW  1      1: in_port==0 means e-stop pressed
// PORTS
//  clk           in   1         system clock
//  reset_n       in   1         asynchronous, active-low reset
//  address       in   2         Avalon word address
//  write         in   1         Avalon write strobe
//  writedata     in   32        Avalon write data
//  readdata      out  32        Avalon read data, registered
//  in_port       in   1         raw e-stop pin, asynchronous to clk
//  drive_enable  out  NUM_AXES  per-axis power-stage enable, registered
//  brake_release out  1         1 = release mechanical brakes (RUN only), registered
//  irq           out  1         level interrupt = irq_pending & irq_en
// BEHAVIOUR
//  Reset: state=IDLE; drive_enable=0; brake_release=0; readdata=0; axis_mask=0.
//   Also irq_pending=0, irq_en=0, trip_count=0, sync regs=inactive, estop_db=0, counters=0.
//  Input: 2-FF synchronizer, polarity-normalised to act (1 = pressed).
//  Assert path: estop_db<=1 on the first edge where act==1; no filtering.
//  Release path: estop_db clears only after DEBOUNCE_CYCLES consecutive act==0 samples.
//   Any act==1 sample restarts the count.
//  Trip latency: in_port asserting -> drive_enable==0 and brake_release==0 by the 4th clk edge.
//  Regs: readdata <= mux(address) every clk; no read side effects; 1-cycle read latency.
//   0 STATUS   RO: [0] estop_db, [1] act, [3:2] state (0 IDLE, 1 RUN, 2 TRIPPED, 3 HOLDOFF),
//              [31:16] trip_count
//   1 CONTROL  WO cmds, self-clearing, reads 0: [0] ARM, [1] CLEAR, [2] SW_STOP
//   2 AXIS_MASK RW [NUM_AXES-1:0]; upper bits read 0
//   3 IRQ      [0] pending: read; write 1 clears. [1] irq_en: RW
//  FSM:
//   IDLE    -> RUN when ARM written and estop_db==0; ARM ignored if estop_db==1.
//   RUN     -> TRIPPED when estop_db==1 or SW_STOP written.
//   IDLE    -> TRIPPED on the same trip conditions.
//   TRIPPED -> HOLDOFF when CLEAR written and estop_db==0; CLEAR ignored while estop_db==1.
//   HOLDOFF -> IDLE after HOLDOFF_CYCLES clocks.
//   HOLDOFF -> TRIPPED on estop_db==1 or SW_STOP; holdoff counter cleared.
//   ARM never goes directly to RUN from TRIPPED or HOLDOFF; restart requires a new ARM in IDLE.
//  Outputs are registered from next-state:
//   drive_enable = (next==RUN) ? axis_mask : 0.
//   brake_release = (next==RUN).
//   AXIS_MASK writes in RUN take effect on drive_enable one clk later.
//  Trip entry: every transition into TRIPPED sets irq_pending and increments trip_count
//   (saturates at 16'hFFFF). SW_STOP while already TRIPPED: no count, no re-set.
//  Priority: SW_STOP > CLEAR > ARM in one write; pending-set beats a same-cycle write-1-to-clear.
//  Reset mid-operation: immediate (asynchronous) return to reset values; drives off without waiting for clk.
// TESTING
//  1 Reset, write AXIS_MASK=0xF, CONTROL=0x1 -> state RUN, drive_enable=4'hF, brake_release=1.
//  2 RUN, in_port 1->0 -> drive_enable=0 by 4th edge; STATUS[3:2]=2; trip_count=1; irq=1 when irq_en=1.
//  3 TRIPPED with e-stop held: CLEAR ignored. Release pin for DEBOUNCE_CYCLES-1 with one glitch -> estop_db stays 1.
//    Then release cleanly, CLEAR -> HOLDOFF, IDLE after HOLDOFF_CYCLES.
//  4 Write CONTROL=0x7 in IDLE -> TRIPPED (SW_STOP wins), ARM ignored.
//    Same-cycle trip and IRQ write-1-to-clear -> pending stays 1.
//  5 Re-assert e-stop during HOLDOFF -> TRIPPED, trip_count+1.
//    Force trip_count=0xFFFF, trip again -> stays 0xFFFF.
//  6 Assert reset_n mid-RUN between clk edges -> drive_enable=0, brake_release=0 immediately; all regs at reset values.

Source files
------------

// File: rtl/soc_system_estop_supervisor.sv
// ---------------------------------------------------------------------------
// soc_system_estop_supervisor
//
// Emergency-stop supervisor for the motor-control fabric. The raw e-stop pin
// is synchronised and normalised so that act==1 means "pressed". A press
// trips immediately; a release is accepted only after DEBOUNCE_CYCLES
// consecutive quiet samples. A four-state FSM (IDLE/RUN/TRIPPED/HOLDOFF)
// gates the per-axis drive enables and the brake release. The HPS reaches
// status and control through a 4-word Avalon-MM slave and a level IRQ.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous, active-low reset
//   address       Avalon word address (0 STATUS, 1 CONTROL, 2 AXIS_MASK, 3 IRQ)
//   write         Avalon write strobe
//   writedata     Avalon write data
//   readdata      Avalon read data, registered, one-cycle latency
//   in_port       raw e-stop pin, asynchronous to clk
//   drive_enable  per-axis power-stage enable, registered
//   brake_release 1 releases the mechanical brakes (RUN only), registered
//   irq           level interrupt, irq_pending & irq_en, registered
// ---------------------------------------------------------------------------
module soc_system_estop_supervisor #(
  parameter int NUM_AXES         = 4,
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int HOLDOFF_CYCLES   = 5000,
  parameter bit ESTOP_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic                in_port,
  output logic [NUM_AXES-1:0] drive_enable,
  output logic                brake_release,
  output logic                irq
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);
  // Pin level that means "not pressed"; the synchroniser resets to it.
  localparam logic PIN_IDLE = ESTOP_ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TRIPPED = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  state_t                state_r, next_s;
  logic [1:0]            sync_r;
  logic                  act_s;
  logic                  estop_db_r;
  logic [DB_W-1:0]       db_cnt_r;
  logic [HO_W-1:0]       ho_cnt_r;
  logic [NUM_AXES-1:0]   axis_mask_r;
  logic                  irq_pending_r, irq_en_r;
  logic                  pending_next_s, en_next_s;
  logic [15:0]           trip_count_r;
  logic                  ctrl_wr_s, mask_wr_s, irq_wr_s;
  logic                  arm_s, clear_s, sw_stop_s, trip_req_s, trip_entry_s;
  logic [NUM_AXES-1:0]   drive_next_s;
  logic                  brake_next_s;
  logic [31:0]           rd_mux_s;
  logic                  unused_wdata_s;

  assign act_s = ESTOP_ACTIVE_LOW ? ~sync_r[1] : sync_r[1];

  // Bus command decode; CONTROL bits are one-shot strobes, never stored.
  assign ctrl_wr_s  = write && (address == 2'd1);
  assign mask_wr_s  = write && (address == 2'd2);
  assign irq_wr_s   = write && (address == 2'd3);
  assign arm_s      = ctrl_wr_s & writedata[0];
  assign clear_s    = ctrl_wr_s & writedata[1];
  assign sw_stop_s  = ctrl_wr_s & writedata[2];
  assign trip_req_s = estop_db_r | sw_stop_s;
  assign unused_wdata_s = &{1'b0, writedata};

  // Two-flop synchroniser for the asynchronous e-stop pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_r <= {2{PIN_IDLE}};
    else          sync_r <= {sync_r[0], in_port};
  end

  // Asymmetric filter: press latches at once, release needs a quiet run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estop_db_r <= 1'b0;
      db_cnt_r   <= '0;
    end else if (act_s) begin
      estop_db_r <= 1'b1;
      db_cnt_r   <= '0;
    end else if (estop_db_r) begin
      if (db_cnt_r == DB_LAST) begin
        estop_db_r <= 1'b0;
        db_cnt_r   <= '0;
      end else begin
        db_cnt_r   <= db_cnt_r + DB_W'(1);
      end
    end else begin
      db_cnt_r <= '0;
    end
  end

  // FSM state register and holdoff timer (timer only runs while staying in HOLDOFF).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      ho_cnt_r <= '0;
    end else begin
      state_r  <= next_s;
      if ((state_r == ST_HOLDOFF) && (next_s == ST_HOLDOFF)) ho_cnt_r <= ho_cnt_r + HO_W'(1);
      else                                                   ho_cnt_r <= '0;
    end
  end

  // FSM next-state; SW_STOP outranks CLEAR, which outranks ARM.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trip_req_s) next_s = ST_TRIPPED;
        else if (arm_s) next_s = ST_RUN;
        else            next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (trip_req_s) next_s = ST_TRIPPED;
        else            next_s = ST_RUN;
      end
      ST_TRIPPED: begin
        if (clear_s && !sw_stop_s && !estop_db_r) next_s = ST_HOLDOFF;
        else                                      next_s = ST_TRIPPED;
      end
      ST_HOLDOFF: begin
        if (trip_req_s)               next_s = ST_TRIPPED;
        else if (ho_cnt_r == HO_LAST) next_s = ST_IDLE;
        else                          next_s = ST_HOLDOFF;
      end
      default: next_s = ST_TRIPPED;
    endcase
  end

  // FSM outputs, decoded from next state so a trip drops drives on the same edge.
  always_comb begin
    drive_next_s = '0;
    brake_next_s = 1'b0;
    trip_entry_s = (state_r != ST_TRIPPED) && (next_s == ST_TRIPPED);
    if (next_s == ST_RUN) begin
      drive_next_s = axis_mask_r;
      brake_next_s = 1'b1;
    end else begin
      drive_next_s = '0;
      brake_next_s = 1'b0;
    end
  end

  // Registered drive and brake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drive_enable  <= '0;
      brake_release <= 1'b0;
    end else begin
      drive_enable  <= drive_next_s;
      brake_release <= brake_next_s;
    end
  end

  // IRQ next values; a trip entry wins over a same-cycle write-1-to-clear.
  always_comb begin
    pending_next_s = irq_pending_r;
    en_next_s      = irq_en_r;
    if (trip_entry_s)                  pending_next_s = 1'b1;
    else if (irq_wr_s && writedata[0]) pending_next_s = 1'b0;
    else                               pending_next_s = irq_pending_r;
    if (irq_wr_s) en_next_s = writedata[1];
    else          en_next_s = irq_en_r;
  end

  // Control/status registers and the trip counter (saturating).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      axis_mask_r   <= '0;
      irq_pending_r <= 1'b0;
      irq_en_r      <= 1'b0;
      irq           <= 1'b0;
      trip_count_r  <= 16'd0;
    end else begin
      if (mask_wr_s) axis_mask_r <= writedata[NUM_AXES-1:0];
      irq_pending_r <= pending_next_s;
      irq_en_r      <= en_next_s;
      irq           <= pending_next_s & en_next_s;
      if (trip_entry_s && (trip_count_r != 16'hFFFF)) trip_count_r <= trip_count_r + 16'd1;
    end
  end

  // Read mux; reads have no side effects.
  always_comb begin
    rd_mux_s = 32'd0;
    case (address)
      2'd0:    rd_mux_s = {trip_count_r, 12'd0, state_r, act_s, estop_db_r};
      2'd1:    rd_mux_s = 32'd0;
      2'd2:    rd_mux_s = {{(32-NUM_AXES){1'b0}}, axis_mask_r};
      2'd3:    rd_mux_s = {30'd0, irq_en_r, irq_pending_r};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= 32'd0;
    else          readdata <= rd_mux_s;
  end

endmodule

// File: tb/tb_soc_system_estop_supervisor.sv
module tb_soc_system_estop_supervisor;

  localparam int NA = 4;
  localparam int DB = 8;
  localparam int HO = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        in_port;
  logic [NA-1:0] drive_enable;
  logic        brake_release;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        rd_chk;
    logic [31:0] exp_rd;
    logic [3:0]  exp_de;
    logic        exp_br;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[14];
  sb_t  sb_q[$];

  soc_system_estop_supervisor #(
    .NUM_AXES(NA), .DEBOUNCE_CYCLES(DB), .HOLDOFF_CYCLES(HO), .ESTOP_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port),
    .drive_enable(drive_enable), .brake_release(brake_release), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      write = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    address = a; write = 1'b0;
    sb_q.push_back('{exp, name});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk(e.name, readdata, e.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // wr, addr, wdata, rd_chk, exp_rd, exp_de, exp_br
    vecs[0]  = '{1'b1, 2'd2, 32'h0000_000F, 1'b0, 32'h0, 4'h0, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 32'h0,         1'b1, 32'hF, 4'h0, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 32'hFFFF_FFF5, 1'b0, 32'h0, 4'h0, 1'b0};
    vecs[3]  = '{1'b0, 2'd2, 32'h0,         1'b1, 32'h5, 4'h0, 1'b0};
    vecs[4]  = '{1'b1, 2'd2, 32'h0000_000F, 1'b0, 32'h0, 4'h0, 1'b0};
    vecs[5]  = '{1'b1, 2'd1, 32'h0000_0001, 1'b0, 32'h0, 4'hF, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, 32'h0,         1'b1, 32'h4, 4'hF, 1'b1};
    vecs[7]  = '{1'b0, 2'd1, 32'h0,         1'b1, 32'h0, 4'hF, 1'b1};
    vecs[8]  = '{1'b1, 2'd2, 32'h0000_0003, 1'b0, 32'h0, 4'hF, 1'b1};
    vecs[9]  = '{1'b0, 2'd2, 32'h0,         1'b1, 32'h3, 4'h3, 1'b1};
    vecs[10] = '{1'b1, 2'd2, 32'h0000_000F, 1'b0, 32'h0, 4'h3, 1'b1};
    vecs[11] = '{1'b0, 2'd3, 32'h0,         1'b1, 32'h0, 4'hF, 1'b1};
    vecs[12] = '{1'b1, 2'd3, 32'h0000_0002, 1'b0, 32'h0, 4'hF, 1'b1};
    vecs[13] = '{1'b0, 2'd3, 32'h0,         1'b1, 32'h2, 4'hF, 1'b1};

    reset_n = 1'b0; in_port = 1'b1; address = 2'd0; write = 1'b0; writedata = 32'd0;
    #12;
    chk("reset_drive_enable", {28'd0, drive_enable}, 32'h0);
    chk("reset_brake", {31'd0, brake_release}, 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd(2'd0, 32'h0, "reset_status");

    // Register access and arming, table driven.
    for (int i = 0; i < 14; i++) begin
      address = vecs[i].addr; writedata = vecs[i].wdata; write = vecs[i].wr;
      if (vecs[i].rd_chk) sb_q.push_back('{vecs[i].exp_rd, $sformatf("vec%0d_readdata", i)});
      @(posedge clk); #1;
      write = 1'b0;
      if (vecs[i].rd_chk) begin
        sb_t e;
        e = sb_q.pop_front();
        chk(e.name, readdata, e.exp);
      end
      chk($sformatf("vec%0d_drive_enable", i), {28'd0, drive_enable}, {28'd0, vecs[i].exp_de});
      chk($sformatf("vec%0d_brake", i), {31'd0, brake_release}, {31'd0, vecs[i].exp_br});
    end

    // E-stop press in RUN: drives off by the 4th edge.
    in_port = 1'b0;
    idle(4);
    chk("trip_drive_enable", {28'd0, drive_enable}, 32'h0);
    chk("trip_brake", {31'd0, brake_release}, 32'h0);
    chk("trip_irq", {31'd0, irq}, 32'h1);
    rd(2'd0, 32'h0001_000B, "trip_status");
    rd(2'd3, 32'h0000_0003, "trip_irq_reg");

    // CLEAR while held is ignored; a glitch restarts the release filter.
    wr(2'd1, 32'h2);
    rd(2'd0, 32'h0001_000B, "clear_ignored_status");
    in_port = 1'b1; idle(5);
    in_port = 1'b0; idle(1);
    in_port = 1'b1; idle(DB + 1);
    rd(2'd0, 32'h0001_0009, "glitch_db_held");
    rd(2'd0, 32'h0001_0008, "db_released");
    wr(2'd1, 32'h2);
    for (int i = 0; i < HO; i++) rd(2'd0, 32'h0001_000C, $sformatf("holdoff_%0d", i));
    rd(2'd0, 32'h0001_0000, "holdoff_done_idle");

    // CONTROL=7 in IDLE: SW_STOP wins, ARM ignored.
    wr(2'd1, 32'h7);
    chk("swstop_drive_enable", {28'd0, drive_enable}, 32'h0);
    rd(2'd0, 32'h0002_0008, "swstop_status");
    wr(2'd3, 32'h3);
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    rd(2'd3, 32'h0000_0002, "irq_reg_cleared");

    // Back to RUN, then trip on the same edge as a write-1-to-clear.
    wr(2'd1, 32'h2);
    idle(HO);
    wr(2'd1, 32'h1);
    chk("rearm_drive_enable", {28'd0, drive_enable}, 32'hF);
    in_port = 1'b0;
    idle(3);
    wr(2'd3, 32'h3);
    chk("trip_w1c_drive_enable", {28'd0, drive_enable}, 32'h0);
    chk("trip_w1c_irq", {31'd0, irq}, 32'h1);
    rd(2'd3, 32'h0000_0003, "trip_w1c_irq_reg");
    rd(2'd0, 32'h0003_000B, "trip_w1c_status");

    // Re-press during HOLDOFF.
    in_port = 1'b1; idle(DB + 2);
    wr(2'd1, 32'h2);
    rd(2'd0, 32'h0003_000C, "holdoff_entered");
    in_port = 1'b0; idle(4);
    rd(2'd0, 32'h0004_000B, "holdoff_retrip");
    wr(2'd3, 32'h3);
    wr(2'd1, 32'h4);
    rd(2'd3, 32'h0000_0002, "swstop_in_tripped_no_pending");
    rd(2'd0, 32'h0004_000B, "swstop_in_tripped_no_count");

    // Trip counter saturation.
    in_port = 1'b1; idle(DB + 2);
    force dut.trip_count_r = 16'hFFFE;
    idle(1);
    release dut.trip_count_r;
    rd(2'd0, 32'hFFFE_0008, "count_preset");
    wr(2'd1, 32'h2);
    wr(2'd1, 32'h4);
    rd(2'd0, 32'hFFFF_0008, "count_reaches_max");
    wr(2'd1, 32'h2);
    wr(2'd1, 32'h4);
    rd(2'd0, 32'hFFFF_0008, "count_saturated");

    // Asynchronous reset mid-RUN.
    wr(2'd1, 32'h2);
    idle(HO);
    wr(2'd1, 32'h1);
    chk("prereset_drive_enable", {28'd0, drive_enable}, 32'hF);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_drive_enable", {28'd0, drive_enable}, 32'h0);
    chk("async_reset_brake", {31'd0, brake_release}, 32'h0);
    chk("async_reset_irq", {31'd0, irq}, 32'h0);
    chk("async_reset_readdata", readdata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd(2'd0, 32'h0, "post_reset_status");
    rd(2'd2, 32'h0, "post_reset_mask");
    rd(2'd3, 32'h0, "post_reset_irq_reg");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
